// File: rtl/fpu_issue_controller.sv
// Issue controller for a fixed-latency FloatingPointUnit: accepts one request,
// times the op's latency, captures the result and holds it until the consumer takes it.
module fpu_issue_controller #(
   parameter int LAT_ADD  = 7,
   parameter int LAT_MULT = 5,
   parameter int LAT_DIV  = 28,
   parameter int LAT_CVT  = 6,
   parameter int LAT_SQRT = 28
) (
   input  logic        iClk,
   input  logic        iRstN,
   input  logic        iFlush,
   input  logic        iReqValid,
   output logic        oReqReady,
   input  logic [2:0]  iReqOp,
   input  logic [31:0] iReqSrc0,
   input  logic [31:0] iReqSrc1,
   input  logic [3:0]  iReqTag,
   output logic [2:0]  oFpuOp,
   output logic [31:0] oFpuSrc0,
   output logic [31:0] oFpuSrc1,
   input  logic [31:0] iFpuResult,
   output logic        oRspValid,
   input  logic        iRspReady,
   output logic [31:0] oRspData,
   output logic [3:0]  oRspTag,
   output logic        oRspErr,
   output logic        oBusy,
   output logic [15:0] oOpCount
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} stateT;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MULT = 3'b010;
   localparam logic [2:0] OP_DIV  = 3'b011;
   localparam logic [2:0] OP_FTOI = 3'b100;
   localparam logic [2:0] OP_ITOF = 3'b101;
   localparam logic [2:0] OP_SQRT = 3'b110;

   stateT       state;
   stateT       nextState;
   logic [4:0]  latCount;
   logic [4:0]  latLoad;
   logic [15:0] opCountQ;
   logic        accept;
   logic        legalOp;

   assign legalOp   = (iReqOp != 3'b111);
   assign oReqReady = (state == IDLE) && iRstN;
   assign accept    = iReqValid && oReqReady && !iFlush;
   assign oRspValid = (state == DONE);
   assign oBusy     = (state != IDLE);
   assign oOpCount  = opCountQ;

   always_comb begin
      latLoad = 5'd0;
      case (iReqOp)
         OP_ADD, OP_SUB:   latLoad = 5'(LAT_ADD);
         OP_MULT:          latLoad = 5'(LAT_MULT);
         OP_DIV:           latLoad = 5'(LAT_DIV);
         OP_FTOI, OP_ITOF: latLoad = 5'(LAT_CVT);
         OP_SQRT:          latLoad = 5'(LAT_SQRT);
         default:          latLoad = 5'd0;
      endcase
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) state <= IDLE;
      else        state <= nextState;
   end

   // Flush wins over both acceptance and the response handshake.
   always_comb begin
      nextState = state;
      if (iFlush) begin
         nextState = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) nextState = legalOp ? EXEC : DONE;
            EXEC:    if (latCount == 5'd1) nextState = DONE;
            DONE:    if (iRspReady) nextState = IDLE;
            default: nextState = IDLE;
         endcase
      end
   end

   // Illegal ops leave the FPU op untouched and complete immediately with an error.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         oFpuOp   <= 3'b000;
         oFpuSrc0 <= 32'd0;
         oFpuSrc1 <= 32'd0;
         oRspData <= 32'd0;
         oRspTag  <= 4'd0;
         oRspErr  <= 1'b0;
         latCount <= 5'd0;
         opCountQ <= 16'd0;
      end else if (iFlush) begin
         latCount <= 5'd0;
      end else if (accept) begin
         oFpuSrc0 <= iReqSrc0;
         oFpuSrc1 <= iReqSrc1;
         oRspTag  <= iReqTag;
         if (legalOp) begin
            oFpuOp   <= iReqOp;
            oRspErr  <= 1'b0;
            latCount <= latLoad;
         end else begin
            oRspData <= 32'd0;
            oRspErr  <= 1'b1;
            latCount <= 5'd0;
         end
      end else if (state == EXEC) begin
         latCount <= latCount - 5'd1;
         if (latCount == 5'd1) oRspData <= iFpuResult;
      end else if ((state == DONE) && iRspReady) begin
         opCountQ <= opCountQ + 16'd1;
      end
   end

endmodule

// File: tb/tb_fpu_issue_controller.sv
// Directed bench for fpu_issue_controller: vector table of single ops plus
// hand-written stall, flush, reset and counter-wrap sequences.
module tb_fpu_issue_controller;

   logic        iClk = 1'b0;
   logic        iRstN = 1'b0;
   logic        iFlush = 1'b0;
   logic        iReqValid = 1'b0;
   logic        oReqReady;
   logic [2:0]  iReqOp = 3'b000;
   logic [31:0] iReqSrc0 = 32'd0;
   logic [31:0] iReqSrc1 = 32'd0;
   logic [3:0]  iReqTag = 4'd0;
   logic [2:0]  oFpuOp;
   logic [31:0] oFpuSrc0;
   logic [31:0] oFpuSrc1;
   logic [31:0] iFpuResult;
   logic        oRspValid;
   logic        iRspReady = 1'b0;
   logic [31:0] oRspData;
   logic [3:0]  oRspTag;
   logic        oRspErr;
   logic        oBusy;
   logic [15:0] oOpCount;

   fpu_issue_controller dut (
      .iClk(iClk), .iRstN(iRstN), .iFlush(iFlush), .iReqValid(iReqValid),
      .oReqReady(oReqReady), .iReqOp(iReqOp), .iReqSrc0(iReqSrc0), .iReqSrc1(iReqSrc1),
      .iReqTag(iReqTag), .oFpuOp(oFpuOp), .oFpuSrc0(oFpuSrc0), .oFpuSrc1(oFpuSrc1),
      .iFpuResult(iFpuResult), .oRspValid(oRspValid), .iRspReady(iRspReady),
      .oRspData(oRspData), .oRspTag(oRspTag), .oRspErr(oRspErr), .oBusy(oBusy),
      .oOpCount(oOpCount)
   );

   always #5 iClk = ~iClk;

   // FPU model: the result is only valid on the cycle the op's latency has elapsed.
   int          fpuAge = 0;
   int          modelLat = 0;
   logic [31:0] fpuValue = 32'd0;

   always @(posedge iClk) begin
      if (iReqValid && oReqReady && !iFlush) fpuAge <= 1;
      else                                   fpuAge <= fpuAge + 1;
   end

   assign iFpuResult = (fpuAge == modelLat) ? fpuValue : 32'hDEADBEEF;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] src0;
      logic [31:0] src1;
      logic [3:0]  tag;
      logic [31:0] fpuVal;
      int          expLat;
      logic [31:0] expData;
      logic        expErr;
      logic [2:0]  expFpuOp;
   } vecT;

   vecT         vecs[8];
   int          tests = 0;
   int          fails = 0;
   logic [15:0] expCount = 16'd0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] s0, input logic [31:0] s1,
                                input logic [3:0] tag);
      int w = 0;
      while (!oReqReady && w < 50) begin
         step();
         w++;
      end
      checkOutput("readyBeforeRequest", 32'(oReqReady), 32'd1);
      iReqValid = 1'b1;
      iReqOp    = op;
      iReqSrc0  = s0;
      iReqSrc1  = s1;
      iReqTag   = tag;
      step();
      iReqValid = 1'b0;
   endtask

   task automatic waitResponse(output int lat);
      lat = 0;
      while (!oRspValid && lat < 40) begin
         step();
         lat++;
      end
   endtask

   task automatic handshake(input string name);
      iRspReady = 1'b1;
      step();
      iRspReady = 1'b0;
      expCount = expCount + 16'd1;
      checkOutput({name, ".validAfterTake"}, 32'(oRspValid), 32'd0);
      checkOutput({name, ".busyAfterTake"}, 32'(oBusy), 32'd0);
      checkOutput({name, ".opCount"}, 32'(oOpCount), 32'(expCount));
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, ".fpuOp"}, 32'(oFpuOp), 32'd0);
      checkOutput({name, ".fpuSrc0"}, oFpuSrc0, 32'd0);
      checkOutput({name, ".fpuSrc1"}, oFpuSrc1, 32'd0);
      checkOutput({name, ".rspData"}, oRspData, 32'd0);
      checkOutput({name, ".rspTag"}, 32'(oRspTag), 32'd0);
      checkOutput({name, ".rspErr"}, 32'(oRspErr), 32'd0);
      checkOutput({name, ".rspValid"}, 32'(oRspValid), 32'd0);
      checkOutput({name, ".busy"}, 32'(oBusy), 32'd0);
      checkOutput({name, ".opCount"}, 32'(oOpCount), 32'd0);
      checkOutput({name, ".reqReady"}, 32'(oReqReady), 32'd0);
   endtask

   task automatic checkNoResponse(input string name, input int cycles);
      logic seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (oRspValid) seen = 1'b1;
      end
      checkOutput(name, 32'(seen), 32'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      logic [31:0] heldData;

      vecs[0] = '{3'b000, 32'h3F800000, 32'h40000000, 4'h5, 32'h40400000, 7,  32'h40400000, 1'b0, 3'b000};
      vecs[1] = '{3'b001, 32'h40400000, 32'h3F800000, 4'h1, 32'h40000000, 7,  32'h40000000, 1'b0, 3'b001};
      vecs[2] = '{3'b010, 32'h40000000, 32'h40400000, 4'h2, 32'h40C00000, 5,  32'h40C00000, 1'b0, 3'b010};
      vecs[3] = '{3'b011, 32'h40C00000, 32'h40000000, 4'h3, 32'h40400000, 28, 32'h40400000, 1'b0, 3'b011};
      vecs[4] = '{3'b100, 32'h40A00000, 32'h00000000, 4'h4, 32'h00000005, 6,  32'h00000005, 1'b0, 3'b100};
      vecs[5] = '{3'b101, 32'h00000007, 32'h00000000, 4'h6, 32'h40E00000, 6,  32'h40E00000, 1'b0, 3'b101};
      vecs[6] = '{3'b110, 32'h41100000, 32'h00000000, 4'h7, 32'h40400000, 28, 32'h40400000, 1'b0, 3'b110};
      vecs[7] = '{3'b111, 32'h11111111, 32'h22222222, 4'hA, 32'h12345678, 0,  32'h00000000, 1'b1, 3'b110};

      #12;
      checkAllZero("reset");
      iRstN = 1'b1;
      #1;
      checkOutput("readyAfterRelease", 32'(oReqReady), 32'd1);
      step();

      for (int i = 0; i < 8; i++) begin
         string n;
         n = $sformatf("vec%0d", i);
         modelLat = vecs[i].expLat;
         fpuValue = vecs[i].fpuVal;
         applyStimulus(vecs[i].op, vecs[i].src0, vecs[i].src1, vecs[i].tag);
         waitResponse(lat);
         checkOutput({n, ".latency"}, 32'(lat), 32'(vecs[i].expLat));
         checkOutput({n, ".data"}, oRspData, vecs[i].expData);
         checkOutput({n, ".tag"}, 32'(oRspTag), 32'(vecs[i].tag));
         checkOutput({n, ".err"}, 32'(oRspErr), 32'(vecs[i].expErr));
         checkOutput({n, ".fpuOp"}, 32'(oFpuOp), 32'(vecs[i].expFpuOp));
         checkOutput({n, ".busy"}, 32'(oBusy), 32'd1);
         if (!vecs[i].expErr) begin
            checkOutput({n, ".fpuSrc0"}, oFpuSrc0, vecs[i].src0);
            checkOutput({n, ".fpuSrc1"}, oFpuSrc1, vecs[i].src1);
         end
         handshake(n);
      end

      // DIV response held for 10 cycles by a stalled consumer.
      modelLat = 28;
      fpuValue = 32'h3F000000;
      applyStimulus(3'b011, 32'h3F800000, 32'h40000000, 4'h9);
      waitResponse(lat);
      checkOutput("stall.latency", 32'(lat), 32'd28);
      heldData = 32'h3F000000;
      for (int i = 0; i < 10; i++) begin
         step();
         checkOutput("stall.valid", 32'(oRspValid), 32'd1);
         checkOutput("stall.data", oRspData, heldData);
         checkOutput("stall.tag", 32'(oRspTag), 32'h9);
         checkOutput("stall.ready", 32'(oReqReady), 32'd0);
         checkOutput("stall.opCount", 32'(oOpCount), 32'(expCount));
      end
      handshake("stall");

      // Flush in EXEC cycle 3 of SQRT with a competing request.
      modelLat = 28;
      fpuValue = 32'h40000000;
      applyStimulus(3'b110, 32'h40800000, 32'h0, 4'hB);
      step();
      step();
      iFlush = 1'b1;
      iReqValid = 1'b1;
      iReqOp = 3'b000;
      iReqTag = 4'hC;
      step();
      iFlush = 1'b0;
      iReqValid = 1'b0;
      checkOutput("flushExec.busy", 32'(oBusy), 32'd0);
      checkOutput("flushExec.valid", 32'(oRspValid), 32'd0);
      checkOutput("flushExec.ready", 32'(oReqReady), 32'd1);
      checkNoResponse("flushExec.noResponse", 35);
      checkOutput("flushExec.opCount", 32'(oOpCount), 32'(expCount));

      // Flush beats acceptance in IDLE.
      iFlush = 1'b1;
      iReqValid = 1'b1;
      iReqOp = 3'b010;
      step();
      iFlush = 1'b0;
      iReqValid = 1'b0;
      checkOutput("flushIdle.busy", 32'(oBusy), 32'd0);

      // Flush beats the response handshake in DONE.
      modelLat = 0;
      applyStimulus(3'b111, 32'h0, 32'h0, 4'hE);
      checkOutput("flushDone.validBefore", 32'(oRspValid), 32'd1);
      iFlush = 1'b1;
      iRspReady = 1'b1;
      step();
      iFlush = 1'b0;
      iRspReady = 1'b0;
      checkOutput("flushDone.valid", 32'(oRspValid), 32'd0);
      checkOutput("flushDone.opCount", 32'(oOpCount), 32'(expCount));

      // Asynchronous reset in the middle of a MULT.
      modelLat = 5;
      fpuValue = 32'h41000000;
      applyStimulus(3'b010, 32'h40000000, 32'h40800000, 4'hD);
      step();
      step();
      #2;
      iRstN = 1'b0;
      #1;
      expCount = 16'd0;
      checkAllZero("midReset");
      #1;
      iRstN = 1'b1;
      #1;
      checkOutput("midReset.readyAfterRelease", 32'(oReqReady), 32'd1);
      @(posedge iClk);
      #1;
      checkNoResponse("midReset.noStaleResponse", 10);

      // Counter wrap: preload 65535 completions, then complete one more.
      force dut.opCountQ = 16'hFFFF;
      #1;
      release dut.opCountQ;
      expCount = 16'hFFFF;
      modelLat = 0;
      applyStimulus(3'b111, 32'h0, 32'h0, 4'h2);
      waitResponse(lat);
      checkOutput("wrap.latency", 32'(lat), 32'd0);
      handshake("wrap");
      checkOutput("wrap.zero", 32'(oOpCount), 32'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fpu_issue_controller.md
FPU_ISSUE_CONTROLLER -- requirements
Module: fpu_issue_controller

Interface
REQ-001 SHALL have parameter LAT_ADD, default 7, cycles FloatingPointUnit needs for ADD/SUB.
REQ-002 SHALL have parameter LAT_MULT, default 5, multiply latency.
REQ-003 SHALL have parameter LAT_DIV, default 28, divide latency.
REQ-004 SHALL have parameter LAT_CVT, default 6, FTOI/ITOF latency.
REQ-005 SHALL have parameter LAT_SQRT, default 28, square-root latency; all LAT_* legal range 1..31.
REQ-006 SHALL have ports:
- iClk  in  1  single clock, rising edge.
- iRstN  in  1  reset, asynchronous, active-low.
- iFlush  in  1  synchronous abort.
- iReqValid  in  1  request offered.
- oReqReady  out  1  request accepted when high with iReqValid.
- iReqOp  in  3  op code: 000 ADD, 001 SUB, 010 MULT, 011 DIV, 100 FTOI, 101 ITOF, 110 SQRT.
- iReqSrc0, iReqSrc1  in  32  operands.
- iReqTag  in  4  caller tag.
- oFpuOp  out  3  op to FloatingPointUnit.
- oFpuSrc0, oFpuSrc1  out  32  operands to FloatingPointUnit.
- iFpuResult  in  32  FloatingPointUnit result.
- oRspValid  out  1  response present.
- iRspReady  in  1  consumer takes response.
- oRspData  out  32  result.
- oRspTag  out  4  tag of the request.
- oRspErr  out  1  illegal op code (111).
- oBusy  out  1  state not IDLE.
- oOpCount  out  16  completed responses, wraps.

Function
REQ-007 SHALL implement states IDLE, EXEC, DONE.
REQ-008 IDLE: oReqReady=1; all other states oReqReady=0.
REQ-009 Acceptance (iReqValid & oReqReady, no iFlush) at edge T SHALL register op, sources and tag; oFpuOp/oFpuSrc0/oFpuSrc1 driven from these registers starting after T.
REQ-010 Legal op at acceptance SHALL enter EXEC with 5-bit counter loaded with that op's LAT_* (ADD/SUB -> LAT_ADD, FTOI/ITOF -> LAT_CVT).
REQ-011 In EXEC, counter SHALL decrement each cycle; at the edge where counter==1, iFpuResult SHALL be captured into oRspData and state SHALL go to DONE; oRspValid therefore rises exactly LAT cycles after T.
REQ-012 oFpuOp/oFpuSrc0/oFpuSrc1 SHALL remain constant for the whole of EXEC and DONE and hold their last value in IDLE.
REQ-013 Op 111 at acceptance SHALL go directly to DONE at T with oRspData=0, oRspErr=1, oFpuOp unchanged; legal ops give oRspErr=0.
REQ-014 DONE: oRspValid=1; oRspData/oRspTag/oRspErr SHALL remain stable until iRspReady=1; at that edge state goes to IDLE, oRspValid falls, oOpCount increments.
REQ-015 No back-to-back: next request accepted no earlier than one cycle after response handshake.
REQ-016 oOpCount SHALL wrap FFFF -> 0000 without side effect.
REQ-017 iFlush=1 at any edge SHALL force IDLE, clear counter and oRspValid, discard pending result, not increment oOpCount; iFlush has priority over acceptance and response handshake in the same cycle.
REQ-018 oBusy SHALL be 1 in EXEC and DONE, 0 in IDLE.

Reset
REQ-019 iRstN low SHALL immediately force IDLE and zero every register: oFpuOp=000, oFpuSrc0/1=0, oRspData=0, oRspTag=0, oRspErr=0, oRspValid=0, oBusy=0, oOpCount=0, counter=0.
REQ-020 oReqReady SHALL be 0 while iRstN low and 1 in the first cycle after release.
REQ-021 Reset asserted mid-EXEC or mid-DONE SHALL abandon the operation; no response issued after release.

Verification
REQ-022 ADD 3F800000+40000000, tag 5, model FPU returning 40400000 after 7 cycles -> oRspValid exactly 7 cycles after acceptance, oRspData=40400000, oRspTag=5, oRspErr=0.
REQ-023 DIV accepted, iRspReady held 0 for 10 cycles after oRspValid -> data/tag stable for all 10 cycles, oReqReady=0, oOpCount increments once on release.
REQ-024 iReqOp=111, tag A -> oRspValid next cycle, oRspErr=1, oRspData=0, no EXEC.
REQ-025 iFlush at EXEC cycle 3 of SQRT, new request same cycle -> request not accepted, IDLE next cycle, no response, oOpCount unchanged.
REQ-026 iRstN pulsed low mid-MULT -> all outputs 0 asynchronously, oReqReady=1 first cycle after release, no stale response.
REQ-027 Preload 65535 completions then one more -> oOpCount=0000.
